// File: rtl/sram_pkg.sv
// Macro geometry, row/column index types and the saturating counter helper
// shared by the tiled SRAM wrapper.
package sram_pkg;
    localparam int unsigned M1024X16_ADDR_W = 10;
    localparam int unsigned M1024X16_DATA_W = 16;
    localparam int unsigned MAX_ROW_W       = 8;
    localparam int unsigned MAX_COL_W       = 8;
    localparam int unsigned CNT_W           = 32;

    typedef logic [MAX_ROW_W-1:0] row_idx_t;
    typedef logic [MAX_COL_W-1:0] col_idx_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction
endpackage

// File: rtl/SRAM1RW1024x16.sv
// Behavioural model of the 1024x16 single-port macro: active-low controls,
// registered read data that holds until the next read.
module SRAM1RW1024x16 (
    input  logic        CLK,
    input  logic        CSB,
    input  logic        OEB,
    input  logic        WEB,
    input  logic [9:0]  A,
    input  logic [15:0] I,
    output logic [15:0] O
);
    logic [15:0] mem [1024];

    always_ff @(posedge CLK) begin
        if (!CSB && !WEB) mem[A] <= I;
        if (!CSB && !OEB) O <= mem[A];
    end
endmodule

// File: rtl/sram_tile_col.sv
// One macro tile (one row, one column slice) with its CSB/OEB/WEB decode.
module sram_tile_col
    import sram_pkg::*;
#(
    parameter int unsigned MACRO_ADDR_W = M1024X16_ADDR_W,
    parameter int unsigned MACRO_DATA_W = M1024X16_DATA_W
) (
    input  logic                    i_clk,
    input  logic                    i_act,
    input  logic                    i_sel,
    input  logic                    i_wmode,
    input  logic                    i_wbit,
    input  logic [MACRO_ADDR_W-1:0] i_addr,
    input  logic [MACRO_DATA_W-1:0] i_wdata,
    output logic [MACRO_DATA_W-1:0] o_rdata
);
    logic w_csb;
    logic w_oeb;
    logic w_web;

    assign w_csb = ~(i_act & i_sel);
    assign w_oeb = ~(i_act & i_sel & ~i_wmode);
    assign w_web = ~(i_act & i_sel & i_wmode & i_wbit);

    if (MACRO_ADDR_W == M1024X16_ADDR_W && MACRO_DATA_W == M1024X16_DATA_W) begin : g_macro
        SRAM1RW1024x16 u_macro (
            .CLK (i_clk),
            .CSB (w_csb),
            .OEB (w_oeb),
            .WEB (w_web),
            .A   (i_addr),
            .I   (i_wdata),
            .O   (o_rdata)
        );
    end else begin : g_generic
        // Stand-in array for geometries without a hard macro.
        logic [MACRO_DATA_W-1:0] r_mem [2**MACRO_ADDR_W];
        logic [MACRO_DATA_W-1:0] r_dout;

        always_ff @(posedge i_clk) begin
            if (!w_csb && !w_web) r_mem[i_addr] <= i_wdata;
            if (!w_csb && !w_oeb) r_dout <= r_mem[i_addr];
        end
        assign o_rdata = r_dout;
    end
endmodule

// File: rtl/sram_tiled_wrapper.sv
// Logical SRAM built from NUM_ROWS x NUM_COLS macros with a 3-edge read
// pipeline (request capture, macro access, output register) and counters.
module sram_tiled_wrapper
    import sram_pkg::*;
#(
    parameter int unsigned ADDR_W       = 12,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned MACRO_ADDR_W = M1024X16_ADDR_W,
    parameter int unsigned MACRO_DATA_W = M1024X16_DATA_W,
    localparam int unsigned NUM_ROWS    = 2**(ADDR_W-MACRO_ADDR_W),
    localparam int unsigned NUM_COLS    = DATA_W/MACRO_DATA_W
) (
    input  logic                RW0_clk,
    input  logic                RW0_rst,
    input  logic [ADDR_W-1:0]   RW0_addr,
    input  logic                RW0_en,
    input  logic                RW0_wmode,
    input  logic [DATA_W-1:0]   RW0_wdata,
    input  logic [NUM_COLS-1:0] RW0_wmask,
    output logic [DATA_W-1:0]   RW0_rdata,
    output logic                RW0_rvalid,
    output logic [CNT_W-1:0]    RW0_rd_cnt,
    output logic [CNT_W-1:0]    RW0_wr_cnt
);
    logic [ADDR_W-1:0]   r_addr_q;
    logic                r_en_q;
    logic                r_wmode_q;
    logic [DATA_W-1:0]   r_wdata_q;
    logic [NUM_COLS-1:0] r_wmask_q;
    logic                r_rd_v2;
    row_idx_t            r_row_q2;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_rvalid;
    logic [CNT_W-1:0]    r_rd_cnt;
    logic [CNT_W-1:0]    r_wr_cnt;

    row_idx_t            w_row_q;
    logic                w_act;
    logic [DATA_W-1:0]   w_dout [NUM_ROWS];
    logic [DATA_W-1:0]   w_mux;

    if (NUM_ROWS > 1) begin : g_row
        assign w_row_q = row_idx_t'(r_addr_q[ADDR_W-1:MACRO_ADDR_W]);
    end else begin : g_no_row
        assign w_row_q = '0;
    end

    // Reset blocks any macro access even if a request is sitting in stage 1.
    assign w_act = r_en_q & ~RW0_rst;

    always_ff @(posedge RW0_clk) begin
        if (RW0_rst) begin
            r_addr_q  <= '0;
            r_en_q    <= 1'b0;
            r_wmode_q <= 1'b0;
            r_wdata_q <= '0;
            r_wmask_q <= '0;
            r_rd_v2   <= 1'b0;
            r_row_q2  <= '0;
            r_rdata   <= '0;
            r_rvalid  <= 1'b0;
            r_rd_cnt  <= '0;
            r_wr_cnt  <= '0;
        end else begin
            r_addr_q  <= RW0_addr;
            r_en_q    <= RW0_en;
            r_wmode_q <= RW0_wmode;
            r_wdata_q <= RW0_wdata;
            r_wmask_q <= RW0_wmask;
            r_rd_v2   <= r_en_q & ~r_wmode_q;
            r_row_q2  <= w_row_q;
            r_rvalid  <= r_rd_v2;
            if (r_rd_v2) r_rdata <= w_mux;
            if (RW0_en) begin
                if (RW0_wmode) r_wr_cnt <= sat_inc(r_wr_cnt);
                else           r_rd_cnt <= sat_inc(r_rd_cnt);
            end
        end
    end

    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_rows
        for (genvar c = 0; c < NUM_COLS; c++) begin : g_cols
            sram_tile_col #(
                .MACRO_ADDR_W (MACRO_ADDR_W),
                .MACRO_DATA_W (MACRO_DATA_W)
            ) u_tile (
                .i_clk   (RW0_clk),
                .i_act   (w_act),
                .i_sel   (w_row_q == row_idx_t'(r)),
                .i_wmode (r_wmode_q),
                .i_wbit  (r_wmask_q[c]),
                .i_addr  (r_addr_q[MACRO_ADDR_W-1:0]),
                .i_wdata (r_wdata_q[c*MACRO_DATA_W +: MACRO_DATA_W]),
                .o_rdata (w_dout[r][c*MACRO_DATA_W +: MACRO_DATA_W])
            );
        end
    end

    // Row captured with the read picks the macro row that was accessed.
    always_comb begin
        w_mux = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (r_row_q2 == row_idx_t'(r)) w_mux = w_dout[r];
        end
    end

    assign RW0_rdata  = r_rdata;
    assign RW0_rvalid = r_rvalid;
    assign RW0_rd_cnt = r_rd_cnt;
    assign RW0_wr_cnt = r_wr_cnt;
endmodule

// File: tb/tb_sram_tiled_wrapper.sv
// Scoreboard bench for sram_tiled_wrapper at default geometry (4 rows x 2 cols).
module tb_sram_tiled_wrapper;
    logic        clk;
    logic        rst;
    logic [11:0] addr;
    logic        en;
    logic        wmode;
    logic [31:0] wdata;
    logic [1:0]  wmask;
    logic [31:0] rdata;
    logic        rvalid;
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [31:0] exp_q [$];
    int          iss_q [$];
    logic [31:0] exp_hold = '0;
    logic [31:0] exp_rd = '0;
    logic [31:0] exp_wr = '0;

    sram_tiled_wrapper dut (
        .RW0_clk    (clk),
        .RW0_rst    (rst),
        .RW0_addr   (addr),
        .RW0_en     (en),
        .RW0_wmode  (wmode),
        .RW0_wdata  (wdata),
        .RW0_wmask  (wmask),
        .RW0_rdata  (rdata),
        .RW0_rvalid (rvalid),
        .RW0_rd_cnt (rd_cnt),
        .RW0_wr_cnt (wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [31:0] sat(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every rvalid pops one expected read; otherwise rdata must hold.
    always @(negedge clk) begin
        if (rvalid === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_rvalid: got rdata %h expected no rvalid", rdata);
            end else begin
                logic [31:0] e;
                int          iss;
                e   = exp_q.pop_front();
                iss = iss_q.pop_front();
                exp_hold = e;
                if (rdata !== e) begin
                    n_fail++;
                    $display("FAIL read_data: got %h expected %h", rdata, e);
                end
                chk("read_latency", 32'(cyc - iss), 32'd2);
            end
        end else if (rst === 1'b0) begin
            chk("rdata_hold", rdata, exp_hold);
        end
        if (rst === 1'b1) exp_hold = '0;
    end

    // Drive one request for one edge; reads with chk_rd=1 go to the scoreboard.
    task automatic op(input bit w, input logic [11:0] a, input logic [31:0] d,
                      input logic [1:0] m, input bit chk_rd, input logic [31:0] e);
        en = 1'b1; wmode = w; addr = a; wdata = d; wmask = m;
        if (w) exp_wr = sat(exp_wr);
        else   exp_rd = sat(exp_rd);
        if (!w && chk_rd) begin
            exp_q.push_back(e);
            iss_q.push_back(cyc + 1);
        end
        @(negedge clk);
        en = 1'b0; wmode = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending reads expected 0", exp_q.size());
            exp_q.delete();
            iss_q.delete();
        end
        idle(1);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; wmode = 1'b0; addr = '0; wdata = '0; wmask = '0;
        idle(2);
        chk("reset_rvalid", 32'(rvalid), 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_rd_cnt", rd_cnt, 32'd0);
        chk("reset_wr_cnt", wr_cnt, 32'd0);
        rst = 1'b0;
        idle(1);

        op(1'b1, 12'h000, 32'hDEADBEEF, 2'b11, 1'b0, '0);
        idle(1);
        op(1'b0, 12'h000, '0, 2'b00, 1'b1, 32'hDEADBEEF);
        drain();

        op(1'b1, 12'h400, 32'h12345678, 2'b11, 1'b0, '0);
        op(1'b1, 12'hC00, 32'hCAFEF00D, 2'b11, 1'b0, '0);
        op(1'b1, 12'h805, 32'h0BADC0DE, 2'b11, 1'b0, '0);
        op(1'b0, 12'h000, '0, 2'b00, 1'b1, 32'hDEADBEEF);
        op(1'b0, 12'h400, '0, 2'b00, 1'b1, 32'h12345678);
        op(1'b0, 12'hC00, '0, 2'b00, 1'b1, 32'hCAFEF00D);
        op(1'b0, 12'h805, '0, 2'b00, 1'b1, 32'h0BADC0DE);
        drain();

        op(1'b1, 12'h000, 32'h0000AAAA, 2'b01, 1'b0, '0);
        op(1'b0, 12'h000, '0, 2'b00, 1'b1, 32'hDEADAAAA);
        drain();

        op(1'b1, 12'h400, 32'hFFFFFFFF, 2'b00, 1'b0, '0);
        chk("wr_cnt_zero_mask", wr_cnt, exp_wr);
        op(1'b0, 12'h400, '0, 2'b00, 1'b1, 32'h12345678);
        drain();
        chk("wr_cnt_total", wr_cnt, exp_wr);
        chk("rd_cnt_total", rd_cnt, exp_rd);

        // Read in flight when reset hits must vanish.
        op(1'b0, 12'h400, '0, 2'b00, 1'b0, '0);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        exp_rd = '0; exp_wr = '0;
        chk("rst_rd_cnt", rd_cnt, exp_rd);
        chk("rst_wr_cnt", wr_cnt, exp_wr);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        idle(4);
        op(1'b0, 12'h400, '0, 2'b00, 1'b1, 32'h12345678);
        drain();
        chk("post_rst_rd_cnt", rd_cnt, exp_rd);

        force dut.r_rd_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_rd_cnt;
        exp_rd = 32'hFFFF_FFFE;
        @(negedge clk);
        chk("forced_rd_cnt", rd_cnt, exp_rd);
        op(1'b0, 12'h000, '0, 2'b00, 1'b1, 32'hDEADAAAA);
        op(1'b0, 12'hC00, '0, 2'b00, 1'b1, 32'hCAFEF00D);
        op(1'b0, 12'h400, '0, 2'b00, 1'b1, 32'h12345678);
        drain();
        chk("rd_cnt_saturated", rd_cnt, 32'hFFFF_FFFF);
        chk("rd_cnt_model", rd_cnt, exp_rd);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_tiled_wrapper.md
SRAM_TILED_WRAPPER -- requirements
Module: sram_tiled_wrapper

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 12, meaning logical word-address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning logical word width.
REQ-003 The block SHALL have parameter MACRO_ADDR_W, default 10, meaning macro address width.
REQ-004 The block SHALL have parameter MACRO_DATA_W, default 16, meaning macro data width; DATA_W is an integer multiple of it.
REQ-005 Derived constants SHALL be NUM_ROWS = 2**(ADDR_W-MACRO_ADDR_W) and NUM_COLS = DATA_W/MACRO_DATA_W; one write-mask bit per column.
REQ-006 Port list, clock and reset first:
  RW0_clk  in  1  single clock; all state on its rising edge.
  RW0_rst  in  1  reset, synchronous, active-high.
  RW0_addr  in  ADDR_W  word address.
  RW0_en  in  1  request valid this cycle.
  RW0_wmode  in  1  1 = write, 0 = read.
  RW0_wdata  in  DATA_W  write data.
  RW0_wmask  in  NUM_COLS  per-column write enable.
  RW0_rdata  out  DATA_W  registered read data.
  RW0_rvalid  out  1  RW0_rdata holds a fresh read result.
  RW0_rd_cnt  out  32  saturating count of accepted reads.
  RW0_wr_cnt  out  32  saturating count of accepted writes.

Function
REQ-007 The block SHALL tile NUM_ROWS x NUM_COLS macros: row = RW0_addr[ADDR_W-1:MACRO_ADDR_W], macro address = RW0_addr[MACRO_ADDR_W-1:0], column c holds data bits [c*MACRO_DATA_W +: MACRO_DATA_W].
REQ-008 Stage 1 SHALL register addr, en, wmode, wdata and wmask every cycle; macros are driven only from stage-1 registers.
REQ-009 Macro controls: CSB low only on the selected row when en_q=1; OEB low only for the selected row on reads; WEB low only for the selected row on writes with wmask_q[c]=1.
REQ-010 A write with all-zero wmask SHALL assert CSB but no WEB and still increment RW0_wr_cnt.
REQ-011 Read latency SHALL be 3 edges: request at edge N, stage-1 capture at N, macro access at N+1, output register at N+2; RW0_rvalid is high for exactly one cycle after edge N+2.
REQ-012 Row select SHALL be delayed alongside the read so the output mux picks the row accessed, independent of later requests.
REQ-013 Back-to-back reads (one per cycle, any rows) SHALL be fully pipelined, yielding one RW0_rvalid per read, in order.
REQ-014 A read issued the cycle after a write to the same address SHALL return the new data for mask-enabled columns and old data for the rest.
REQ-015 Writes SHALL never assert RW0_rvalid; RW0_rdata holds its last value when RW0_rvalid=0.
REQ-016 Counters SHALL increment once per accepted request (RW0_en=1 at an edge) and saturate at 32'hFFFFFFFF.
REQ-017 When NUM_ROWS = 1 the row-select logic SHALL reduce to a constant and the row field is absent.

Reset
REQ-018 While RW0_rst=1 at an edge, all stage-1 and pipeline valid flags, RW0_rvalid, RW0_rdata (0), RW0_rd_cnt and RW0_wr_cnt (0) SHALL clear; all macro CSB/WEB/OEB are held high.
REQ-019 Reads in flight when reset asserts SHALL be discarded; no RW0_rvalid for them after reset deasserts.
REQ-020 Macro contents SHALL NOT be cleared by reset.

Structure
REQ-021 Package sram_pkg SHALL hold the macro geometry constants (MACRO_ADDR_W, MACRO_DATA_W per supported macro) and the row/column index typedefs.
REQ-022 One sub-module, sram_tile_col, SHALL wrap a single macro instance (SRAM1RW1024x16 at default geometry) with its CSB/OEB/WEB decode; the top generates NUM_ROWS x NUM_COLS of them.

Verification (defaults: 4 rows x 2 cols of 1024x16)
REQ-023 Write 0x000 <- 0xDEADBEEF mask 2'b11, then read 0x000 -> RW0_rdata=0xDEADBEEF with RW0_rvalid exactly 3 edges after the read request.
REQ-024 Write 0x400 <- 0x12345678, 0xC00 <- 0xCAFEF00D, then back-to-back reads 0x000, 0x400, 0xC00 -> rvalid on three consecutive cycles with 0xDEADBEEF, 0x12345678, 0xCAFEF00D.
REQ-025 Write 0x000 <- 0x0000AAAA mask 2'b01, read next cycle -> 0xDEADAAAA.
REQ-026 Write with mask 2'b00 to 0x400 -> readback 0x12345678 and RW0_wr_cnt increments by 1.
REQ-027 Issue read to 0x400, assert RW0_rst one cycle later -> no RW0_rvalid, counters 0, then read 0x400 -> 0x12345678.
REQ-028 Force RW0_rd_cnt to 32'hFFFFFFFE, issue 3 reads -> counter holds 32'hFFFFFFFF.
